text_vmem: RTL and testbench
============================

// Module: text_vmem
// PURPOSE
//   Parametrised text-mode video memory. Sits between the PS/2 keyboard decoder and the VGA
//   character renderer. Keeps a COLS x ROWS character grid with a cursor, and handles
//   printable, ENTER and BACKSPACE codes. Scrolls in hardware through a ring-buffer top-row
//   pointer, and clears the grid one cell per cycle after reset.
//   Serves the async read port used by the glyph ROM.
// PARAMETERS
//   COLS    70  characters per row
//   ROWS    30  rows on screen
//   CHAR_W  9   glyph width in pixels (h_addr pitch)
//   CHAR_H  16  glyph height in pixels (v_addr pitch)
//   XW = $clog2(COLS), YW = $clog2(ROWS), AW = $clog2(COLS*ROWS)  (localparams)
// PORTS
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   key_in     in   8   ASCII code from keyboard decoder
//   key_valid  in   1   key_in valid this cycle (single-cycle pulse)
//   key_ready  out  1   block accepts a key this cycle
//   key_drop   out  1   sticky: a key arrived while key_ready=0
//   x          in   XW  display column of cell being rendered
//   y          in   YW  display row of cell being rendered
//   h_addr     in   10  VGA pixel column
//   v_addr     in   10  VGA pixel row
//   ascii_out  out  8   character at display cell (x,y)
//   row        out  4   glyph pixel row = (v_addr - y*CHAR_H)[3:0]
//   col        out  4   glyph pixel col = (h_addr - x*CHAR_W)[3:0]
//   cursor_x   out  XW  cursor column
//   cursor_y   out  YW  cursor display row
// BEHAVIOUR
//   Storage and read port
//   - Storage is COLS*ROWS bytes, linear address = phys_row*COLS + col.
//   - phys_row = (y + top_row) mod ROWS.
//   - ascii_out is combinational from (x,y). It returns 0 when x>=COLS or y>=ROWS.
//   - A same-cycle write to the read cell shows the old value until the next clock edge.
//   - row/col are computed in 10-bit arithmetic with the multiplies done explicitly, then
//     truncated to 4 bits.
//   FSM
//   - CLEAR: write 0 to address clr_ptr, clr_ptr++; go to IDLE after address COLS*ROWS-1.
//     Takes exactly COLS*ROWS cycles.
//   - IDLE: key_ready=1. A key is accepted when key_valid && key_ready.
//   - SCROLL: top_row <= (top_row+1) mod ROWS on entry. Then write 0 to every cell of the
//     new bottom logical row, one cell per cycle, COLS cycles, then go to IDLE.
//   - key_ready=1 only in IDLE.
//   - key_valid while key_ready=0: the key is discarded and key_drop is set (no backpressure
//     on PS/2).
//   Accepted keys
//   - 0x20..0x7E: write at cursor, then cursor_x++.
//   - When cursor_x==COLS-1: cursor_x=0 and line feed.
//   - 0x0A or 0x0D: cursor_x=0, line feed.
//   - Line feed: if cursor_y<ROWS-1 then cursor_y++; otherwise cursor_y stays at ROWS-1 and
//     the FSM enters SCROLL. This also applies to a wrap on the last cell.
//   - 0x08: if the cursor is at (0,0), no-op. If cursor_x>0, cursor_x-- and write 0 at the
//     new position. If cursor_x==0, cursor moves to (COLS-1, cursor_y-1) and writes 0 there.
//   - Any other code: accepted, ignored, no state change.
//   Reset
//   - reset (any cycle, including mid CLEAR/SCROLL) enters CLEAR with clr_ptr=0.
//   - reset values: cursor=(0,0), top_row=0, key_ready=0, key_drop=0.
//   - reset does not zero the array in one cycle; the CLEAR sweep does it.
// TESTING
//   1 Release reset -> key_ready low for 2100 cycles then high; every (x,y) reads 0x00.
//   2 Keys 0x41,0x42 -> cells (0,0)=0x41 and (1,0)=0x42; cursor (2,0).
//   3 70 keys of 0x61 on row 0 -> cursor (0,1). A 71st key 0x62 -> cell (0,1)=0x62.
//   4 Cursor (0,1), key 0x08 -> cursor (69,0), cell (69,0)=0x00. Cursor (0,0), key 0x08 ->
//     no change.
//   5 Put 0x41 on row 1, send 30 ENTERs -> the 30th gives key_ready=0 for 70 cycles.
//     Then display row 0 = 0x41 row, row 29 all 0x00, cursor (0,29).
//     A key_valid during the scroll -> key_drop=1 and no cell changes.
//   6 x=3, y=2, h_addr=30, v_addr=37 -> col=3, row=5. x=70 -> ascii_out=0x00.
//   7 Assert reset mid-SCROLL -> cursor (0,0), full 2100-cycle CLEAR, all cells 0.

Source files
------------

// File: rtl/text_vmem_if.sv
// Keyboard-side handshake between the PS/2 decoder and the text memory.
interface text_vmem_if;
    logic [7:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic       key_drop;

    modport master (
        output key_in,
        output key_valid,
        input  key_ready,
        input  key_drop
    );

    modport slave (
        input  key_in,
        input  key_valid,
        output key_ready,
        output key_drop
    );
endinterface

// File: rtl/text_vmem.sv
// Text-mode video memory: COLS x ROWS character grid with cursor, hardware
// scrolling through a ring-buffer top-row pointer, a post-reset clear sweep
// and an asynchronous read port for the glyph renderer.
module text_vmem #(
    parameter  int COLS   = 70,
    parameter  int ROWS   = 30,
    parameter  int CHAR_W = 9,
    parameter  int CHAR_H = 16,
    localparam int XW     = $clog2(COLS),
    localparam int YW     = $clog2(ROWS),
    localparam int AW     = $clog2(COLS * ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    text_vmem_if.slave        kbd,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic [9:0]        h_addr,
    input  logic [9:0]        v_addr,
    output logic [7:0]        ascii_out,
    output logic [3:0]        row,
    output logic [3:0]        col,
    output logic [XW-1:0]     cursor_x,
    output logic [YW-1:0]     cursor_y
);

    localparam logic [XW:0]   COLS_X   = COLS[XW:0];
    localparam logic [YW:0]   ROWS_Y   = ROWS[YW:0];
    localparam logic [XW-1:0] LAST_COL = XW'(COLS - 1);
    localparam logic [YW-1:0] LAST_ROW = YW'(ROWS - 1);
    localparam logic [AW-1:0] LAST_CLR = AW'(COLS * ROWS - 1);
    localparam logic [AW-1:0] LAST_SCR = AW'(COLS - 1);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCROLL} state_t;

    state_t        state_q;
    logic [AW-1:0] clr_ptr_q;
    logic [XW-1:0] cur_x_q;
    logic [YW-1:0] cur_y_q;
    logic [YW-1:0] top_row_q;
    logic          ready_q;
    logic          drop_q;
    logic [7:0]    mem_q [COLS*ROWS];

    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic [AW-1:0] rd_addr;
    logic [9:0]    x_px;
    logic [9:0]    y_px;

    // Display row r maps to physical row (r + top) mod ROWS.
    function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] r,
                                                input logic [XW-1:0] c,
                                                input logic [YW-1:0] top);
        logic [YW:0] p;
        p = {1'b0, r} + {1'b0, top};
        if (p >= ROWS_Y) p = p - ROWS_Y;
        return AW'(p) * AW'(COLS) + AW'(c);
    endfunction

    logic          key_acc;
    logic          is_print;
    logic          is_nl;
    logic          is_bs;
    logic          at_last_col;
    logic          at_last_row;
    logic          bs_home;
    logic          line_feed;
    logic [XW-1:0] bs_x;
    logic [YW-1:0] bs_y;

    assign key_acc     = kbd.key_valid && ready_q;
    assign is_print    = (kbd.key_in >= 8'h20) && (kbd.key_in <= 8'h7E);
    assign is_nl       = (kbd.key_in == 8'h0A) || (kbd.key_in == 8'h0D);
    assign is_bs       = (kbd.key_in == 8'h08);
    assign at_last_col = (cur_x_q == LAST_COL);
    assign at_last_row = (cur_y_q == LAST_ROW);
    assign bs_home     = (cur_x_q == '0) && (cur_y_q == '0);
    assign bs_x        = (cur_x_q != '0) ? cur_x_q - 1'b1 : LAST_COL;
    assign bs_y        = (cur_x_q != '0) ? cur_y_q : cur_y_q - 1'b1;
    assign line_feed   = key_acc && ((is_print && at_last_col) || is_nl);

    // Single write port: clear sweep, scroll row wipe, or key write at the cursor.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        case (state_q)
            S_CLEAR: begin
                we    = 1'b1;
                waddr = clr_ptr_q;
            end
            S_SCROLL: begin
                we    = 1'b1;
                waddr = cell_addr(LAST_ROW, XW'(clr_ptr_q), top_row_q);
            end
            S_IDLE: begin
                if (key_acc && is_print) begin
                    we    = 1'b1;
                    waddr = cell_addr(cur_y_q, cur_x_q, top_row_q);
                    wdata = kbd.key_in;
                end else if (key_acc && is_bs && !bs_home) begin
                    we    = 1'b1;
                    waddr = cell_addr(bs_y, bs_x, top_row_q);
                end
            end
            default: ;
        endcase
        if (reset) we = 1'b0;
    end

    // Character storage, written one cell per cycle.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Control FSM: clear sweep, key handling, scroll wipe; registered ready/drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            top_row_q <= '0;
            ready_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            if (kbd.key_valid && !ready_q) drop_q <= 1'b1;
            case (state_q)
                S_CLEAR: begin
                    if (clr_ptr_q == LAST_CLR) begin
                        state_q   <= S_IDLE;
                        ready_q   <= 1'b1;
                        clr_ptr_q <= '0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                S_SCROLL: begin
                    if (clr_ptr_q == LAST_SCR) begin
                        state_q   <= S_IDLE;
                        ready_q   <= 1'b1;
                        clr_ptr_q <= '0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (key_acc) begin
                        if (is_print) begin
                            cur_x_q <= at_last_col ? '0 : cur_x_q + 1'b1;
                        end else if (is_nl) begin
                            cur_x_q <= '0;
                        end else if (is_bs && !bs_home) begin
                            cur_x_q <= bs_x;
                            cur_y_q <= bs_y;
                        end
                    end
                    if (line_feed) begin
                        if (!at_last_row) begin
                            cur_y_q <= cur_y_q + 1'b1;
                        end else begin
                            state_q   <= S_SCROLL;
                            ready_q   <= 1'b0;
                            clr_ptr_q <= '0;
                            top_row_q <= (top_row_q == LAST_ROW) ? '0 : top_row_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign rd_addr       = cell_addr(y, x, top_row_q);
    assign ascii_out     = (({1'b0, x} < COLS_X) && ({1'b0, y} < ROWS_Y)) ? mem_q[rd_addr] : 8'h00;
    assign x_px          = 10'(x) * 10'(CHAR_W);
    assign y_px          = 10'(y) * 10'(CHAR_H);
    assign col           = 4'(h_addr - x_px);
    assign row           = 4'(v_addr - y_px);
    assign cursor_x      = cur_x_q;
    assign cursor_y      = cur_y_q;
    assign kbd.key_ready = ready_q;
    assign kbd.key_drop  = drop_q;

endmodule

// File: tb/tb_text_vmem.sv
// Self-checking bench for text_vmem against a display-grid reference model.
module tb_text_vmem;
    localparam int COLS = 70;
    localparam int ROWS = 30;
    localparam int XW   = $clog2(COLS);
    localparam int YW   = $clog2(ROWS);

    logic          clk = 1'b0;
    logic          reset;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [9:0]    h_addr;
    logic [9:0]    v_addr;
    logic [7:0]    ascii_out;
    logic [3:0]    row;
    logic [3:0]    col;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;

    text_vmem_if kif();

    text_vmem #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(9), .CHAR_H(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .kbd       (kif),
        .x         (x),
        .y         (y),
        .h_addr    (h_addr),
        .v_addr    (v_addr),
        .ascii_out (ascii_out),
        .row       (row),
        .col       (col),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: grid indexed by display row, scrolling shifts rows up.
    logic [7:0] grid [ROWS][COLS];
    int cx, cy;

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) grid[r][c] = 8'h00;
        cx = 0;
        cy = 0;
    endfunction

    function automatic bit model_key(input logic [7:0] k);
        bit lf = 0;
        if (k >= 8'h20 && k <= 8'h7E) begin
            grid[cy][cx] = k;
            if (cx == COLS - 1) begin cx = 0; lf = 1; end
            else cx++;
        end else if (k == 8'h0A || k == 8'h0D) begin
            cx = 0; lf = 1;
        end else if (k == 8'h08) begin
            if (cx > 0) begin cx--; grid[cy][cx] = 8'h00; end
            else if (cy > 0) begin cx = COLS - 1; cy--; grid[cy][cx] = 8'h00; end
        end
        if (lf) begin
            if (cy < ROWS - 1) cy++;
            else begin
                for (int r = 0; r < ROWS - 1; r++) grid[r] = grid[r + 1];
                for (int c = 0; c < COLS; c++) grid[ROWS - 1][c] = 8'h00;
                return 1;
            end
        end
        return 0;
    endfunction

    task automatic do_reset();
        int n;
        @(negedge clk);
        reset = 1'b1;
        kif.key_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_clear();
        n_checks++;
        if (cursor_x !== 0 || cursor_y !== 0 || kif.key_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: cursor=(%0d,%0d) drop=%b, want (0,0) drop=0", cursor_x, cursor_y, kif.key_drop);
        end
        n = 0;
        while (!kif.key_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n !== COLS * ROWS) begin
            n_fail++;
            $display("FAIL clear_len: ready low %0d cycles, want %0d", n, COLS * ROWS);
        end
    endtask

    task automatic check_screen(input string tag);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                @(negedge clk);
                x = XW'(c);
                y = YW'(r);
                #1;
                n_checks++;
                if (ascii_out !== grid[r][c]) begin
                    n_fail++;
                    $display("FAIL %s cell(%0d,%0d): got %h want %h", tag, c, r, ascii_out, grid[r][c]);
                end
            end
        end
    endtask

    task automatic send_key(input logic [7:0] k, input bit probe);
        int w;
        int n;
        bit sc;
        @(negedge clk);
        w = 0;
        while (!kif.key_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: key_ready=%b, want 1", kif.key_ready);
        end
        kif.key_in    = k;
        kif.key_valid = 1'b1;
        @(posedge clk);
        #1;
        kif.key_valid = 1'b0;
        sc = model_key(k);
        if (sc) begin
            n_checks++;
            if (kif.key_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL scroll_busy: key_ready=%b, want 0", kif.key_ready);
            end
            @(negedge clk);
            n = 0;
            while (!kif.key_ready && n < 500) begin
                if (probe && n == 3) begin kif.key_in = 8'h5A; kif.key_valid = 1'b1; end
                else kif.key_valid = 1'b0;
                n++;
                @(negedge clk);
            end
            kif.key_valid = 1'b0;
            n_checks++;
            if (n !== COLS) begin
                n_fail++;
                $display("FAIL scroll_len: ready low %0d cycles, want %0d", n, COLS);
            end
            if (probe) begin
                n_checks++;
                if (kif.key_drop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL key_drop: got %b want 1", kif.key_drop);
                end
            end
        end
        n_checks++;
        if (cursor_x !== XW'(cx) || cursor_y !== YW'(cy)) begin
            n_fail++;
            $display("FAIL cursor key=%h: got (%0d,%0d) want (%0d,%0d)", k, cursor_x, cursor_y, cx, cy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_screen("reset_clear");
    endtask

    task automatic test_print();
        send_key(8'h41, 0);
        send_key(8'h42, 0);
        n_checks++;
        if (cursor_x !== 2 || cursor_y !== 0) begin
            n_fail++;
            $display("FAIL print_cursor: got (%0d,%0d) want (2,0)", cursor_x, cursor_y);
        end
        check_screen("print");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < COLS; i++) send_key(8'h61, 0);
        n_checks++;
        if (cursor_x !== 0 || cursor_y !== 1) begin
            n_fail++;
            $display("FAIL wrap_cursor: got (%0d,%0d) want (0,1)", cursor_x, cursor_y);
        end
        send_key(8'h62, 0);
        check_screen("wrap");
    endtask

    task automatic test_backspace();
        send_key(8'h08, 0);
        send_key(8'h08, 0);
        n_checks++;
        if (cursor_x !== COLS - 1 || cursor_y !== 0) begin
            n_fail++;
            $display("FAIL bs_wrap: got (%0d,%0d) want (%0d,0)", cursor_x, cursor_y, COLS - 1);
        end
        for (int i = 0; i < COLS; i++) send_key(8'h08, 0);
        n_checks++;
        if (cursor_x !== 0 || cursor_y !== 0) begin
            n_fail++;
            $display("FAIL bs_home: got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
        end
        check_screen("backspace");
    endtask

    task automatic test_scroll();
        do_reset();
        send_key(8'h0A, 0);
        for (int i = 0; i < 5; i++) send_key(8'h41, 0);
        while (cy < ROWS - 1) send_key(8'h0D, 0);
        send_key(8'h0A, 1);
        n_checks++;
        if (cursor_x !== 0 || cursor_y !== ROWS - 1) begin
            n_fail++;
            $display("FAIL scroll_cursor: got (%0d,%0d) want (0,%0d)", cursor_x, cursor_y, ROWS - 1);
        end
        check_screen("scroll");
    endtask

    task automatic test_random();
        logic [7:0] k;
        do_reset();
        for (int i = 0; i < 700; i++) begin
            case ($urandom_range(0, 9))
                6: k = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
                7: k = 8'h08;
                8: begin
                    k = 8'($urandom_range(0, 255));
                    if ((k >= 8'h20 && k <= 8'h7E) || k == 8'h0A || k == 8'h0D || k == 8'h08) k = 8'h01;
                end
                default: k = 8'($urandom_range(32, 126));
            endcase
            send_key(k, ($urandom_range(0, 3) == 0));
        end
        check_screen("random");
    endtask

    task automatic test_render();
        int ex, ey;
        @(negedge clk);
        x = 3; y = 2; h_addr = 10'd30; v_addr = 10'd37;
        #1;
        n_checks++;
        if (col !== 4'd3 || row !== 4'd5) begin
            n_fail++;
            $display("FAIL render_fixed: col=%0d row=%0d want col=3 row=5", col, row);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            x = XW'($urandom_range(0, 127));
            y = YW'($urandom_range(0, 31));
            h_addr = 10'($urandom_range(0, 1023));
            v_addr = 10'($urandom_range(0, 1023));
            #1;
            ex = (int'(h_addr) - int'(x) * 9) & 15;
            ey = (int'(v_addr) - int'(y) * 16) & 15;
            n_checks++;
            if (col !== 4'(ex) || row !== 4'(ey)) begin
                n_fail++;
                $display("FAIL render_pitch: col=%0d row=%0d want %0d %0d", col, row, ex, ey);
            end
            n_checks++;
            if (int'(x) >= COLS || int'(y) >= ROWS) begin
                if (ascii_out !== 8'h00) begin
                    n_fail++;
                    $display("FAIL render_oob (%0d,%0d): got %h want 00", x, y, ascii_out);
                end
            end else if (ascii_out !== grid[y][x]) begin
                n_fail++;
                $display("FAIL render_cell (%0d,%0d): got %h want %h", x, y, ascii_out, grid[y][x]);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            @(negedge clk);
            x = XW'(COLS);
            y = YW'(r);
            #1;
            n_checks++;
            if (ascii_out !== 8'h00) begin
                n_fail++;
                $display("FAIL render_x70 row %0d: got %h want 00", r, ascii_out);
            end
        end
    endtask

    task automatic test_reset_mid_scroll();
        while (cy < ROWS - 1) send_key(8'h0A, 0);
        @(negedge clk);
        kif.key_in = 8'h0A;
        kif.key_valid = 1'b1;
        @(negedge clk);
        kif.key_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (kif.key_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midscroll_busy: key_ready=%b want 0", kif.key_ready);
        end
        do_reset();
        check_screen("reset_mid_scroll");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        kif.key_in = 8'h00;
        kif.key_valid = 1'b0;
        x = '0; y = '0; h_addr = '0; v_addr = '0;
        model_clear();
        test_reset();
        test_print();
        test_wrap();
        test_backspace();
        test_scroll();
        test_random();
        test_render();
        test_reset_mid_scroll();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
